// File: rtl/state_array_ctrl.sv
// Controller for a set-associative 2-bit state array: clears the array after reset,
// serves set lookups and performs read-modify-write single-entry updates.
module state_array_ctrl #(
  parameter int SETS = 128,
  parameter int WAYS = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_read_valid,
  output logic                io_read_ready,
  input  logic [6:0]          io_read_bits_setIdx,
  output logic                io_resp_valid,
  output logic [WAYS*4-1:0]   io_resp_bits_data,
  input  logic                io_update_valid,
  output logic                io_update_ready,
  input  logic [6:0]          io_update_bits_setIdx,
  input  logic [3:0]          io_update_bits_way,
  input  logic                io_update_bits_entry,
  input  logic [1:0]          io_update_bits_state,
  output logic                io_update_err,
  output logic                io_init_done,
  output logic                sram_rreq_valid,
  output logic [6:0]          sram_rreq_setIdx,
  input  logic [WAYS*4-1:0]   sram_rdata,
  output logic                sram_wreq_valid,
  output logic [6:0]          sram_wreq_setIdx,
  output logic [WAYS*4-1:0]   sram_wreq_data,
  output logic [WAYS-1:0]     sram_wreq_waymask
);

  localparam int DATA_W = WAYS * 4;
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_UPD_WR = 2'd2;
  localparam logic [6:0] LAST_SET  = 7'(SETS - 1);

  logic [1:0]        r_state;
  logic [6:0]        r_cnt;
  logic              r_resp_pend;
  logic [6:0]        r_set;
  logic [3:0]        r_way;
  logic              r_entry;
  logic [1:0]        r_new;

  logic              w_idle;
  logic              w_upd_fire;
  logic              w_read_fire;
  logic              w_way_ok;
  logic [DATA_W-1:0] w_merge;
  logic [WAYS-1:0]   w_onehot;

  // Every output is forced low while reset is held, including the combinational ones.
  assign w_idle            = (r_state == ST_IDLE) && !reset;
  assign io_update_ready   = w_idle;
  assign io_read_ready     = w_idle && !io_update_valid;
  assign w_upd_fire        = w_idle && io_update_valid;
  assign w_read_fire       = io_read_ready && io_read_valid;
  assign w_way_ok          = ({1'b0, r_way} < 5'(WAYS));
  assign io_update_err     = !reset && (r_state == ST_UPD_WR) && !w_way_ok;
  assign io_resp_valid     = !reset && r_resp_pend;
  assign io_resp_bits_data = io_resp_valid ? sram_rdata : {DATA_W{1'b0}};
  assign io_init_done      = !reset && ((r_state == ST_IDLE) || (r_state == ST_UPD_WR));

  // Merge the new state into the fetched set and build the one-hot way mask.
  always_comb begin
    w_merge  = sram_rdata;
    w_onehot = {WAYS{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      w_onehot[w] = (r_way == 4'(w));
      for (int e = 0; e < 2; e++) begin
        if ((r_way == 4'(w)) && (r_entry == 1'(e))) begin
          w_merge[(w*2+e)*2 +: 2] = r_new;
        end else begin
          w_merge[(w*2+e)*2 +: 2] = sram_rdata[(w*2+e)*2 +: 2];
        end
      end
    end
  end

  // Array read port: an accepted update fetches its set ahead of a lookup.
  always_comb begin
    sram_rreq_valid  = 1'b0;
    sram_rreq_setIdx = 7'd0;
    if (w_upd_fire) begin
      sram_rreq_valid  = 1'b1;
      sram_rreq_setIdx = io_update_bits_setIdx;
    end else if (w_read_fire) begin
      sram_rreq_valid  = 1'b1;
      sram_rreq_setIdx = io_read_bits_setIdx;
    end else begin
      sram_rreq_valid  = 1'b0;
      sram_rreq_setIdx = 7'd0;
    end
  end

  // Array write port: clear sweep during INIT, masked merge write in UPD_WR.
  always_comb begin
    sram_wreq_valid   = 1'b0;
    sram_wreq_setIdx  = 7'd0;
    sram_wreq_data    = {DATA_W{1'b0}};
    sram_wreq_waymask = {WAYS{1'b0}};
    if (!reset && (r_state == ST_INIT)) begin
      sram_wreq_valid   = 1'b1;
      sram_wreq_setIdx  = r_cnt;
      sram_wreq_waymask = {WAYS{1'b1}};
    end else if (!reset && (r_state == ST_UPD_WR) && w_way_ok) begin
      sram_wreq_valid   = 1'b1;
      sram_wreq_setIdx  = r_set;
      sram_wreq_data    = w_merge;
      sram_wreq_waymask = w_onehot;
    end else begin
      sram_wreq_valid   = 1'b0;
    end
  end

  // Control FSM, clear counter, pending-response flag and captured update.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= 7'd0;
      r_resp_pend <= 1'b0;
      r_set       <= 7'd0;
      r_way       <= 4'd0;
      r_entry     <= 1'b0;
      r_new       <= 2'd0;
    end else begin
      r_resp_pend <= w_read_fire;
      case (r_state)
        ST_INIT: begin
          if (r_cnt == LAST_SET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 7'd0;
          end else begin
            r_cnt   <= r_cnt + 7'd1;
          end
        end
        ST_IDLE: begin
          if (w_upd_fire) begin
            r_state <= ST_UPD_WR;
            r_set   <= io_update_bits_setIdx;
            r_way   <= io_update_bits_way;
            r_entry <= io_update_bits_entry;
            r_new   <= io_update_bits_state;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_UPD_WR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= 7'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_state_array_ctrl.sv
// Scoreboard bench for state_array_ctrl with a behavioural 1-cycle-latency SRAM model.
module tb_state_array_ctrl;

  typedef struct packed {
    logic [6:0]  set;
    logic [39:0] data;
    logic [9:0]  mask;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_read_valid;
  logic        io_read_ready;
  logic [6:0]  io_read_bits_setIdx;
  logic        io_resp_valid;
  logic [39:0] io_resp_bits_data;
  logic        io_update_valid;
  logic        io_update_ready;
  logic [6:0]  io_update_bits_setIdx;
  logic [3:0]  io_update_bits_way;
  logic        io_update_bits_entry;
  logic [1:0]  io_update_bits_state;
  logic        io_update_err;
  logic        io_init_done;
  logic        sram_rreq_valid;
  logic [6:0]  sram_rreq_setIdx;
  logic [39:0] sram_rdata;
  logic        sram_wreq_valid;
  logic [6:0]  sram_wreq_setIdx;
  logic [39:0] sram_wreq_data;
  logic [9:0]  sram_wreq_waymask;

  logic [39:0] mem [0:127];
  logic [39:0] ref_mem [0:127];
  wr_t         exp_wr[$];
  logic [39:0] exp_resp[$];
  wr_t         last_wr;
  logic [39:0] last_resp;
  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  int          resp_seen = 0;
  int          err_seen = 0;

  always #5 clock = ~clock;

  state_array_ctrl #(.SETS(128), .WAYS(10)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_read_valid         (io_read_valid),
    .io_read_ready         (io_read_ready),
    .io_read_bits_setIdx   (io_read_bits_setIdx),
    .io_resp_valid         (io_resp_valid),
    .io_resp_bits_data     (io_resp_bits_data),
    .io_update_valid       (io_update_valid),
    .io_update_ready       (io_update_ready),
    .io_update_bits_setIdx (io_update_bits_setIdx),
    .io_update_bits_way    (io_update_bits_way),
    .io_update_bits_entry  (io_update_bits_entry),
    .io_update_bits_state  (io_update_bits_state),
    .io_update_err         (io_update_err),
    .io_init_done          (io_init_done),
    .sram_rreq_valid       (sram_rreq_valid),
    .sram_rreq_setIdx      (sram_rreq_setIdx),
    .sram_rdata            (sram_rdata),
    .sram_wreq_valid       (sram_wreq_valid),
    .sram_wreq_setIdx      (sram_wreq_setIdx),
    .sram_wreq_data        (sram_wreq_data),
    .sram_wreq_waymask     (sram_wreq_waymask)
  );

  // SRAM model: read data one cycle after the request, 4-bit lanes enabled per way.
  always @(posedge clock) begin
    if (sram_rreq_valid) sram_rdata <= mem[sram_rreq_setIdx];
    if (sram_wreq_valid) begin
      for (int w = 0; w < 10; w++) begin
        if (sram_wreq_waymask[w]) mem[sram_wreq_setIdx][w*4 +: 4] <= sram_wreq_data[w*4 +: 4];
      end
    end
  end

  task automatic monitor();
    wr_t         e;
    logic [39:0] r;
    forever begin
      @(negedge clock);
      if (sram_rreq_valid === 1'b1) begin
        checks++;
        if (sram_wreq_valid !== 1'b0) begin
          errors++;
          $display("FAIL rd_wr_overlap wreq_valid=%b expected 0", sram_wreq_valid);
        end
      end
      if (sram_wreq_valid === 1'b1) begin
        wr_seen++;
        last_wr = {sram_wreq_setIdx, sram_wreq_data, sram_wreq_waymask};
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL sram_write got set=%0d data=%h mask=%h expected no write",
                   sram_wreq_setIdx, sram_wreq_data, sram_wreq_waymask);
        end else begin
          e = exp_wr.pop_front();
          if (last_wr !== e) begin
            errors++;
            $display("FAIL sram_write got set=%0d data=%h mask=%h expected set=%0d data=%h mask=%h",
                     last_wr.set, last_wr.data, last_wr.mask, e.set, e.data, e.mask);
          end
        end
      end
      if (io_resp_valid === 1'b1) begin
        resp_seen++;
        last_resp = io_resp_bits_data;
        checks++;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL resp got data=%h expected no response", io_resp_bits_data);
        end else begin
          r = exp_resp.pop_front();
          if (io_resp_bits_data !== r) begin
            errors++;
            $display("FAIL resp got data=%h expected %h", io_resp_bits_data, r);
          end
        end
      end
      if (io_update_err === 1'b1) err_seen++;
    end
  endtask

  // Drives n cycles of the post-reset clear sweep, starting just after reset drops.
  task automatic run_init(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({7'(i), 40'h0, 10'h3ff});
      ref_mem[i] = 40'h0;
      @(negedge clock);
      if (sram_wreq_valid !== 1'b1 || sram_wreq_setIdx !== 7'(i) || io_read_ready !== 1'b0 ||
          io_update_ready !== 1'b0 || io_init_done !== 1'b0) bad++;
      @(posedge clock); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_sequence bad cycles=%0d expected 0", bad);
    end
    if (n == 128) begin
      @(negedge clock);
      checks++;
      if (io_init_done !== 1'b1 || io_update_ready !== 1'b1 || io_read_ready !== 1'b1 ||
          sram_wreq_valid !== 1'b0) begin
        errors++;
        $display("FAIL init_done got done=%b urdy=%b rrdy=%b wvalid=%b expected 1 1 1 0",
                 io_init_done, io_update_ready, io_read_ready, sram_wreq_valid);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic do_update(input logic [6:0] s, input logic [3:0] w, input logic e,
                           input logic [1:0] st);
    int k;
    io_update_valid       = 1'b1;
    io_update_bits_setIdx = s;
    io_update_bits_way    = w;
    io_update_bits_entry  = e;
    io_update_bits_state  = st;
    if (w < 4'd10) begin
      k = (int'(w) * 2 + int'(e)) * 2;
      ref_mem[s][k +: 2] = st;
      exp_wr.push_back({s, ref_mem[s], 10'h001 << w});
    end
    @(negedge clock);
    checks++;
    if (io_update_ready !== 1'b1 || sram_rreq_valid !== 1'b1 || sram_rreq_setIdx !== s ||
        io_read_ready !== 1'b0) begin
      errors++;
      $display("FAIL upd_accept got urdy=%b rvalid=%b rset=%0d rrdy=%b expected 1 1 %0d 0",
               io_update_ready, sram_rreq_valid, sram_rreq_setIdx, io_read_ready, s);
    end
    @(posedge clock); #1;
    io_update_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_update_ready !== 1'b0 || io_update_err !== (w >= 4'd10) ||
        sram_wreq_valid !== (w < 4'd10) || sram_rreq_valid !== 1'b0) begin
      errors++;
      $display("FAIL upd_write got urdy=%b err=%b wvalid=%b rvalid=%b expected 0 %b %b 0",
               io_update_ready, io_update_err, sram_wreq_valid, sram_rreq_valid,
               (w >= 4'd10), (w < 4'd10));
    end
    @(posedge clock); #1;
  endtask

  task automatic do_read(input logic [6:0] s);
    io_read_valid       = 1'b1;
    io_read_bits_setIdx = s;
    exp_resp.push_back(ref_mem[s]);
    @(negedge clock);
    checks++;
    if (io_read_ready !== 1'b1 || sram_rreq_valid !== 1'b1 || sram_rreq_setIdx !== s) begin
      errors++;
      $display("FAIL read_accept got rrdy=%b rvalid=%b rset=%0d expected 1 1 %0d",
               io_read_ready, sram_rreq_valid, sram_rreq_setIdx, s);
    end
    @(posedge clock); #1;
    io_read_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_latency got resp_valid=%b expected 1", io_resp_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_read_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({io_read_ready, io_resp_valid, io_resp_bits_data, io_update_ready, io_update_err,
         io_init_done, sram_rreq_valid, sram_rreq_setIdx, sram_wreq_valid, sram_wreq_setIdx,
         sram_wreq_data, sram_wreq_waymask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rrdy=%b urdy=%b done=%b rvalid=%b wvalid=%b expected all 0",
               io_read_ready, io_update_ready, io_init_done, sram_rreq_valid, sram_wreq_valid);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    exp_resp.push_back(40'h0);
    run_init(128);
    io_read_valid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (resp_seen != 1 || exp_wr.size() != 0 || exp_resp.size() != 0) begin
      errors++;
      $display("FAIL drain_reset got resps=%0d pend_wr=%0d pend_resp=%0d expected 1 0 0",
               resp_seen, exp_wr.size(), exp_resp.size());
    end
  endtask

  task automatic test_update_read();
    do_update(7'd5, 4'd3, 1'b1, 2'd2);
    checks++;
    if (last_wr.set !== 7'd5 || last_wr.data !== 40'h00_0000_8000 || last_wr.mask !== 10'h008) begin
      errors++;
      $display("FAIL update_write got set=%0d data=%h mask=%h expected 5 0000008000 008",
               last_wr.set, last_wr.data, last_wr.mask);
    end
    do_read(7'd5);
    checks++;
    if (last_resp !== 40'h00_0000_8000) begin
      errors++;
      $display("FAIL update_readback got %h expected 0000008000", last_resp);
    end
  endtask

  task automatic test_merge();
    do_update(7'd9, 4'd0, 1'b0, 2'd1);
    do_update(7'd9, 4'd0, 1'b1, 2'd3);
    checks++;
    if (last_wr.data[3:0] !== 4'b1101 || last_wr.mask !== 10'h001) begin
      errors++;
      $display("FAIL merge got data[3:0]=%b mask=%h expected 1101 001", last_wr.data[3:0], last_wr.mask);
    end
    do_read(7'd9);
  endtask

  task automatic test_back_to_back();
    int r0 = resp_seen;
    io_read_valid = 1'b1;  io_read_bits_setIdx = 7'd5;
    io_update_valid = 1'b1; io_update_bits_setIdx = 7'd5;
    io_update_bits_way = 4'd2; io_update_bits_entry = 1'b0; io_update_bits_state = 2'd3;
    ref_mem[5][9:8] = 2'd3;
    exp_wr.push_back({7'd5, ref_mem[5], 10'h004});
    exp_resp.push_back(ref_mem[5]);
    @(negedge clock);
    checks++;
    if (io_update_ready !== 1'b1 || io_read_ready !== 1'b0 || sram_rreq_setIdx !== 7'd5) begin
      errors++;
      $display("FAIL prio_accept got urdy=%b rrdy=%b rset=%0d expected 1 0 5",
               io_update_ready, io_read_ready, sram_rreq_setIdx);
    end
    @(posedge clock); #1;
    io_update_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_read_ready !== 1'b0 || sram_wreq_valid !== 1'b1 || io_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_updwr got rrdy=%b wvalid=%b resp=%b expected 0 1 0",
               io_read_ready, sram_wreq_valid, io_resp_valid);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (io_read_ready !== 1'b1 || sram_rreq_valid !== 1'b1 || io_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_read got rrdy=%b rvalid=%b resp=%b expected 1 1 0",
               io_read_ready, sram_rreq_valid, io_resp_valid);
    end
    @(posedge clock); #1;
    io_read_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (resp_seen != r0 + 1 || exp_wr.size() != 0 || exp_resp.size() != 0) begin
      errors++;
      $display("FAIL prio_drain got resps=%0d pend_wr=%0d pend_resp=%0d expected %0d 0 0",
               resp_seen - r0, exp_wr.size(), exp_resp.size(), 1);
    end
  endtask

  task automatic test_bad_way();
    int w0 = wr_seen;
    int e0 = err_seen;
    do_update(7'd5, 4'd12, 1'b0, 2'd1);
    checks++;
    if (err_seen != e0 + 1 || wr_seen != w0) begin
      errors++;
      $display("FAIL bad_way got err_pulses=%0d writes=%0d expected 1 0", err_seen - e0, wr_seen - w0);
    end
    do_read(7'd5);
    checks++;
    if (last_resp !== 40'h00_0000_8300) begin
      errors++;
      $display("FAIL bad_way_readback got %h expected 0000008300", last_resp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [6:0] s;
      s = 7'($urandom_range(0, 3) * 31);
      do_update(s, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      do_read(s);
    end
    checks++;
    if (exp_wr.size() != 0 || exp_resp.size() != 0) begin
      errors++;
      $display("FAIL drain_random got pend_wr=%0d pend_resp=%0d expected 0 0", exp_wr.size(), exp_resp.size());
    end
  endtask

  task automatic test_reset_mid();
    int r0 = resp_seen;
    io_read_valid = 1'b1; io_read_bits_setIdx = 7'd5;
    @(posedge clock); #1;
    io_read_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b0 || sram_wreq_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp got resp=%b wvalid=%b expected 0 0", io_resp_valid, sram_wreq_valid);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    run_init(20);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    run_init(128);
    checks++;
    if (resp_seen != r0) begin
      errors++;
      $display("FAIL reset_squash got resps=%0d expected 0", resp_seen - r0);
    end
    io_update_valid = 1'b1; io_update_bits_setIdx = 7'd3;
    io_update_bits_way = 4'd1; io_update_bits_entry = 1'b0; io_update_bits_state = 2'd2;
    @(posedge clock); #1;
    io_update_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (sram_wreq_valid !== 1'b0 || io_update_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_updwr got wvalid=%b err=%b expected 0 0", sram_wreq_valid, io_update_err);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    run_init(128);
    do_read(7'd3);
    checks++;
    if (last_resp !== 40'h0 || exp_wr.size() != 0 || exp_resp.size() != 0) begin
      errors++;
      $display("FAIL reset_upd_drain got data=%h pend_wr=%0d pend_resp=%0d expected 0 0 0",
               last_resp, exp_wr.size(), exp_resp.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    io_read_valid = 1'b0; io_read_bits_setIdx = 7'd0;
    io_update_valid = 1'b0; io_update_bits_setIdx = 7'd0;
    io_update_bits_way = 4'd0; io_update_bits_entry = 1'b0; io_update_bits_state = 2'd0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 40'h0;
    fork
      monitor();
    join_none
    test_reset();
    test_update_read();
    test_merge();
    test_back_to_back();
    test_bad_way();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/state_array_ctrl.md
STATE_ARRAY_CTRL -- requirements
Module: state_array_ctrl

Interface
REQ-001 The block SHALL have parameter SETS, default 128, giving the number of sets; the set index is 7 bits.
REQ-002 The block SHALL have parameter WAYS, default 10, giving the ways per set; each way holds 2 entries of 2-bit state.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, as the following ports.
REQ-004 clock  in  1  block clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 io_read_valid / io_read_ready  in/out  1/1  lookup request handshake.
REQ-007 io_read_bits_setIdx  in  7  lookup set.
REQ-008 io_resp_valid  out  1  lookup data valid (one-cycle pulse).
REQ-009 io_resp_bits_data  out  40  lookup data; field k = way*2+entry occupies bits [2k+1:2k].
REQ-010 io_update_valid / io_update_ready  in/out  1/1  single-entry state update handshake.
REQ-011 io_update_bits_setIdx / _way / _entry / _state  in  7/4/1/2  target set, way, entry and new state.
REQ-012 io_update_err  out  1  one-cycle pulse: an update had way >= WAYS and was dropped.
REQ-013 io_init_done  out  1  high once the array clear has finished.
REQ-014 sram_rreq_valid / sram_rreq_setIdx  out  1/7  array read port.
REQ-015 sram_rdata  in  40  array read data, same field layout, valid exactly 1 cycle after an un-overridden read.
REQ-016 sram_wreq_valid / sram_wreq_setIdx / sram_wreq_data / sram_wreq_waymask  out  1/7/40/10  array write port; waymask bit w enables field pair w.

Function
REQ-017 The block SHALL implement the FSM states INIT, IDLE and UPD_WR.
REQ-018 INIT SHALL write all-zero data with waymask 0x3FF to sets 0..SETS-1, one set per cycle, using a 7-bit counter, then go to IDLE.
REQ-019 io_init_done SHALL go high and stay high from the first IDLE cycle until the next reset.
REQ-020 io_update_ready SHALL equal (state==IDLE).
REQ-021 io_read_ready SHALL equal (state==IDLE && !io_update_valid); an update has priority over a lookup.
REQ-022 When a read is accepted, the block SHALL drive sram_rreq_valid=1 with the request's setIdx in the same cycle.
REQ-023 io_resp_valid SHALL pulse exactly 1 cycle after a read is accepted, and io_resp_bits_data SHALL equal sram_rdata in that cycle.
REQ-024 When an update is accepted, the block SHALL issue an SRAM read of its set in the same cycle, register way/entry/state/set, and enter UPD_WR.
REQ-025 In UPD_WR the block SHALL write sram_rdata with only field (way*2+entry) replaced, with waymask = one-hot(way), then return to IDLE; update latency from accept to write is 1 cycle and throughput is 1 update per 2 cycles.
REQ-026 If the update way >= WAYS, UPD_WR SHALL issue no write and SHALL pulse io_update_err instead.
REQ-027 The block SHALL never assert sram_rreq_valid and sram_wreq_valid in the same cycle.
REQ-028 A lookup accepted after the UPD_WR cycle of an update to the same set SHALL return the updated data; no forwarding path is required.
REQ-029 io_resp_valid SHALL NOT be asserted for update-internal reads.

Reset
REQ-030 While reset is high, all outputs SHALL be 0, the FSM SHALL be set to INIT, the counter SHALL be cleared, and any pending response or update SHALL be squashed.
REQ-031 The first cycle after reset deasserts SHALL write set 0; set 127 SHALL be written in cycle 128; cycle 129 SHALL be IDLE with io_init_done=1.
REQ-032 Reset asserted mid-INIT or mid-update SHALL restart the clear from set 0; a response due in the cycle after reset SHALL NOT be emitted.

Verification
REQ-033 Release reset, then hold io_read_valid -> 128 writes (sets 0..127, data 0, waymask 0x3FF), io_read_ready=0 for 128 cycles, io_init_done=1 at cycle 129.
REQ-034 After init, update set 5, way 3, entry 1, state 2, then read set 5 -> write data bit[15:14]=2'b10 with all other bits 0, waymask 0x008; resp data = 0x0000_00_8000 (bit 15 set).
REQ-035 Two updates to set 9 (way 0 entry 0 state 1, then way 0 entry 1 state 3) -> second write data [3:0]=4'b1101, proving the merge kept entry 0.
REQ-036 Read and update valid in the same IDLE cycle -> update accepted, io_read_ready=0, read accepted 2 cycles later, exactly one io_resp_valid.
REQ-037 Update with way=12 -> no sram_wreq_valid, io_update_err pulses in the cycle after accept, and the next read shows array contents unchanged.
REQ-038 Assert reset in the cycle after a read is accepted and in the UPD_WR cycle -> no io_resp_valid, no update write, and INIT restarts at set 0.
